// File: rtl/mole_hit_checker_if.sv
// Player-facing bus of the mole hit checker: round request, keys, and round status/score.
interface mole_hit_checker_if;
    localparam int unsigned MOLE_W  = 5;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned LIVES_W = 3;

    logic                 load;
    logic [MOLE_W-1:0]    molesGenerated;
    logic [MOLE_W-1:0]    keys;
    logic [MOLE_W-1:0]    molesActive;
    logic                 ready;
    logic                 hit;
    logic                 miss;
    logic [SCORE_W-1:0]   score;
    logic [LIVES_W-1:0]   livesLeft;
    logic                 gameOver;

    // master: mole generator / player side; slave: the checker
    modport master (
        output load, molesGenerated, keys,
        input  molesActive, ready, hit, miss, score, livesLeft, gameOver
    );

    modport slave (
        input  load, molesGenerated, keys,
        output molesActive, ready, hit, miss, score, livesLeft, gameOver
    );
endinterface

// File: rtl/mole_hit_checker.sv
// Whack-a-mole round checker: latches one mole, times the reaction window,
// classifies the round as hit or miss and keeps saturating score and lives.
module mole_hit_checker #(
    parameter int unsigned WINDOW = 50000000,
    parameter int unsigned LIVES  = 3
) (
    input  logic                clock,
    input  logic                reset,
    mole_hit_checker_if.slave   bus
);
    localparam int unsigned MOLE_W  = 5;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned TIMER_W = $clog2(WINDOW + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACTIVE    = 3'd1;
    localparam logic [2:0] S_HIT       = 3'd2;
    localparam logic [2:0] S_MISS      = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [2:0]          state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [MOLE_W-1:0]   keys_q;
    logic [MOLE_W-1:0]   moles_q, moles_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic                hit_q, miss_q, ready_q, over_q;

    logic [MOLE_W-1:0]   key_rise_c;
    logic                one_hot_c;

    // keys_q resets to all-ones so a key held through reset is never a rising edge
    assign key_rise_c = bus.keys & ~keys_q;
    assign one_hot_c  = (bus.molesGenerated != '0) &&
                        ((bus.molesGenerated & (bus.molesGenerated - MOLE_W'(1))) == '0);

    // next-state and datapath updates
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        moles_d = moles_q;
        score_d = score_q;
        lives_d = lives_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load && one_hot_c) begin
                    moles_d = bus.molesGenerated;
                    timer_d = TIMER_W'(WINDOW - 1);
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if ((key_rise_c & moles_q) != '0) begin
                    state_d = S_HIT;
                    moles_d = '0;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if ((key_rise_c != '0) || (timer_q == '0)) begin
                    state_d = S_MISS;
                    moles_d = '0;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_HIT: begin
                state_d = S_IDLE;
            end
            S_MISS: begin
                state_d = (lives_q == '0) ? S_GAME_OVER : S_IDLE;
            end
            S_GAME_OVER: begin
                moles_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                moles_d = '0;
            end
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // datapath and registered outputs decoded from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            keys_q  <= '1;
            moles_q <= '0;
            score_q <= '0;
            lives_q <= LIVES_W'(LIVES);
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            ready_q <= 1'b1;
            over_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            keys_q  <= bus.keys;
            moles_q <= moles_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= (state_d == S_HIT);
            miss_q  <= (state_d == S_MISS);
            ready_q <= (state_d == S_IDLE);
            over_q  <= (state_d == S_GAME_OVER);
        end
    end

    assign bus.molesActive = moles_q;
    assign bus.ready       = ready_q;
    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.score       = score_q;
    assign bus.livesLeft   = lives_q;
    assign bus.gameOver    = over_q;

endmodule

// File: tb/tb_mole_hit_checker.sv
// Scoreboard bench for mole_hit_checker: rounds are modelled from the game rules,
// expected hit/miss pulses are queued and checked by an independent monitor.
module tb_mole_hit_checker;
    localparam int unsigned W = 8;
    localparam int unsigned L = 3;

    typedef struct {
        bit          is_hit;
        int unsigned cyc;
        logic [7:0]  score;
        logic [2:0]  lives;
    } exp_t;

    logic clock;
    logic reset;
    int unsigned cyc = 0;
    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    int unsigned m_score;
    int unsigned m_lives;
    bit          m_over;

    mole_hit_checker_if bus ();

    mole_hit_checker #(.WINDOW(W), .LIVES(L)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every hit/miss pulse must match the oldest expected round outcome
    always @(negedge clock) begin
        if (reset && (bus.hit || bus.miss)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'({bus.hit, bus.miss}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind_hit", 32'(bus.hit), 32'(e.is_hit));
                chk("pulse_kind_miss", 32'(bus.miss), 32'(!e.is_hit));
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_score", 32'(bus.score), 32'(e.score));
                chk("pulse_lives", 32'(bus.livesLeft), 32'(e.lives));
                chk("pulse_moles_clear", 32'(bus.molesActive), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_score = 0;
        m_lives = L;
        m_over  = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset(input logic [4:0] base);
        reset = 1'b0;
        bus.load = 1'b0;
        bus.molesGenerated = '0;
        bus.keys = base;
        #1;
        chk("rst_moles", 32'(bus.molesActive), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_miss", 32'(bus.miss), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_lives", 32'(bus.livesLeft), L);
        chk("rst_gameover", 32'(bus.gameOver), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 3 * W + 10) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("pulse_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_over && !bus.ready && n < 3 * W + 10) begin
            tick();
            n++;
        end
        if (!m_over && !bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    // one round: load pattern, then press 'press' on top of held 'base' keys
    // in active cycle d (d=0: no press; d>W: press lands after the window)
    task automatic run_round(input logic [4:0] pattern, input int d,
                             input logic [4:0] press, input logic [4:0] base);
        int unsigned c;
        bit          acc, over0, inwin;
        logic [4:0]  rise;
        exp_t        e;
        wait_ready();
        c = cyc;
        over0 = m_over;
        bus.keys = base;
        bus.load = 1'b1;
        bus.molesGenerated = pattern;
        acc = !m_over && ($countones(pattern) == 1);
        if (acc) begin
            rise  = press & ~base;
            inwin = (d >= 1) && (d <= int'(W));
            if (inwin && ((rise & pattern) != '0)) begin
                e.is_hit = 1'b1;
                e.cyc    = c + d + 1;
                if (m_score != 255) m_score++;
            end else begin
                e.is_hit = 1'b0;
                e.cyc    = (inwin && rise != '0) ? c + d + 1 : c + W + 1;
                if (m_lives != 0) m_lives--;
                if (m_lives == 0) m_over = 1'b1;
            end
            e.score = 8'(m_score);
            e.lives = 3'(m_lives);
            sb.push_back(e);
        end
        tick();
        bus.load = 1'b0;
        bus.molesGenerated = 5'($urandom);
        chk("moles_latched", 32'(bus.molesActive), acc ? 32'(pattern) : 32'd0);
        chk("ready_after_load", 32'(bus.ready), acc ? 32'd0 : 32'(!over0));
        for (int k = 1; k <= ((d > 1) ? d : 1); k++) begin
            bus.keys = (k == d) ? (base | press) : base;
            tick();
        end
        bus.keys = base;
        wait_done();
        chk("end_score", 32'(bus.score), m_score);
        chk("end_lives", 32'(bus.livesLeft), m_lives);
        chk("end_gameover", 32'(bus.gameOver), 32'(m_over));
        chk("end_ready", 32'(bus.ready), 32'(!m_over));
        chk("end_moles", 32'(bus.molesActive), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          bitn;
        logic [4:0]  pat, wrong, press;
        reset = 1'b0;
        bus.load = 1'b0;
        bus.molesGenerated = '0;
        bus.keys = '0;
        model_reset();
        tick();
        do_reset(5'b00000);

        // directed: hit, timeout, wrong key, same-cycle right+wrong
        run_round(5'b00100, 3, 5'b00100, 5'b00000);
        run_round(5'b00001, 0, 5'b00000, 5'b00000);
        run_round(5'b01000, 2, 5'b00001, 5'b00000);
        run_round(5'b01000, 4, 5'b01001, 5'b00000);
        run_round(5'b00010, W, 5'b00010, 5'b00000);

        // key held through reset, invalid loads, release and re-press
        do_reset(5'b00010);
        run_round(5'b00010, 3, 5'b00010, 5'b00010);
        run_round(5'b00110, 2, 5'b00100, 5'b00010);
        run_round(5'b00000, 2, 5'b00100, 5'b00010);
        run_round(5'b00010, 3, 5'b00010, 5'b00000);

        // lives exhausted by timeouts, then everything ignored until reset
        do_reset(5'b00000);
        for (int i = 0; i < 3; i++) run_round(5'b00001, 0, 5'b00000, 5'b00000);
        run_round(5'b00100, 2, 5'b00100, 5'b00000);
        run_round(5'b10000, 1, 5'b11111, 5'b00000);
        do_reset(5'b00000);

        // randomized rounds; reset whenever the game ends
        for (int i = 0; i < 120; i++) begin
            bitn  = $urandom_range(0, 4);
            pat   = 5'(1 << bitn);
            wrong = 5'(1 << ((bitn + $urandom_range(1, 4)) % 5));
            if ($urandom_range(0, 9) == 0) pat = 5'($urandom);
            case ($urandom_range(0, 4))
                0, 1:    press = 5'(1 << bitn);
                2:       press = wrong;
                3:       press = 5'(1 << bitn) | wrong;
                default: press = 5'($urandom);
            endcase
            run_round(pat, $urandom_range(0, W + 2), press, 5'b00000);
            if (m_over) begin
                run_round(5'b00001, 1, 5'b00001, 5'b00000);
                do_reset(5'b00000);
            end
        end

        // score saturation
        do_reset(5'b00000);
        for (int i = 0; i < 258; i++) begin
            pat = 5'(1 << $urandom_range(0, 4));
            run_round(pat, $urandom_range(1, 2), pat, 5'b00000);
        end
        chk("score_saturated", 32'(bus.score), 32'd255);

        // reset in the middle of an active round
        wait_ready();
        bus.load = 1'b1;
        bus.molesGenerated = 5'b10000;
        tick();
        bus.load = 1'b0;
        chk("midreset_moles_before", 32'(bus.molesActive), 32'h10);
        tick();
        bus.keys = 5'b10000;
        reset = 1'b0;
        #1;
        chk("midreset_moles", 32'(bus.molesActive), 32'd0);
        chk("midreset_hit", 32'(bus.hit), 32'd0);
        chk("midreset_miss", 32'(bus.miss), 32'd0);
        chk("midreset_score", 32'(bus.score), 32'd0);
        chk("midreset_lives", 32'(bus.livesLeft), L);
        chk("midreset_ready", 32'(bus.ready), 32'd1);
        tick();
        reset = 1'b1;
        model_reset();
        bus.keys = 5'b00000;
        repeat (W + 4) tick();
        chk("midreset_idle_ready", 32'(bus.ready), 32'd1);
        chk("midreset_idle_moles", 32'(bus.molesActive), 32'd0);
        run_round(5'b00100, 2, 5'b00100, 5'b00000);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
